// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 binary32 multiplier.
// Operands are latched on start in IDLE. A 24-step shift-add multiply runs in
// MUL, followed by one NORM cycle, one ROUND cycle and a one-cycle DONE strobe.
// Special operands (NaN, Inf, zero, subnormal) go straight from IDLE to DONE.
// Subnormals are treated as zero, and results that underflow are flushed to zero.
// Optional macro FP_MUL_ROUND_EN: when it is defined, ROUND does
// round-to-nearest-even. When it is undefined, ROUND truncates. Both builds
// have the same latency.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic [31:0] result_out,
  output logic        done,
  output logic        busy
);

`ifdef FP_MUL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [4:0]  step_r;
  logic [47:0] prod_r;
  logic        sticky_r;
  logic        norm_r;

  // Operand classification helpers (exponent 0 counts as zero: subnormals flush)
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

  logic        special_s;
  logic [31:0] special_res_s;
  logic        in_sign_s;

  // Detect operands that bypass the multiplier and compute their fixed result
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'h0;
    in_sign_s     = A_in[31] ^ B_in[31];
    if (is_nan(A_in) || is_nan(B_in) ||
        (is_inf(A_in) && is_zero(B_in)) || (is_zero(A_in) && is_inf(B_in))) begin
      special_s     = 1'b1;
      special_res_s = QNAN;
    end else if (is_inf(A_in) || is_inf(B_in)) begin
      special_s     = 1'b1;
      special_res_s = {in_sign_s, 8'hFF, 23'h0};
    end else if (is_zero(A_in) || is_zero(B_in)) begin
      special_s     = 1'b1;
      special_res_s = {in_sign_s, 31'h0};
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'h0;
    end
  end

  // One shift-add step: add the multiplicand into the upper half, then shift right
  logic [23:0] a_mant_s;
  logic [23:0] b_mant_s;
  logic        b_bit_s;
  logic [24:0] sum_s;

  always_comb begin
    a_mant_s = {1'b1, a_r[22:0]};
    b_mant_s = {1'b1, b_r[22:0]};
    b_bit_s  = b_mant_s[step_r];
    if (b_bit_s) begin
      sum_s = {1'b0, prod_r[47:24]} + {1'b0, a_mant_s};
    end else begin
      sum_s = {1'b0, prod_r[47:24]};
    end
  end

  // Rounding and final packing. After NORM the leading one sits at prod_r[46].
  logic        sign_s;
  logic [9:0]  exp_base_s;
  logic [9:0]  exp_fin_s;
  logic [23:0] mant_s;
  logic        guard_s;
  logic        round_s;
  logic        sticky_s;
  logic        inc_s;
  logic [24:0] mant_rnd_s;
  logic [22:0] frac_s;
  logic        carry_s;
  logic [31:0] round_res_s;

  always_comb begin
    sign_s     = a_r[31] ^ b_r[31];
    exp_base_s = {2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - 10'd127;
    mant_s     = prod_r[46:23];
    guard_s    = prod_r[22];
    round_s    = prod_r[21];
    sticky_s   = (|prod_r[20:0]) | sticky_r;
    inc_s      = ROUND_EN & guard_s & (round_s | sticky_s | mant_s[0]);
    mant_rnd_s = {1'b0, mant_s} + {24'h0, inc_s};
    carry_s    = mant_rnd_s[24];
    if (carry_s) begin
      frac_s = mant_rnd_s[23:1];
    end else begin
      frac_s = mant_rnd_s[22:0];
    end
    exp_fin_s = exp_base_s + {9'h0, norm_r} + {9'h0, carry_s};
    if ($signed(exp_fin_s) >= $signed(10'sd255)) begin
      round_res_s = {sign_s, 8'hFF, 23'h0};
    end else if ($signed(exp_fin_s) <= $signed(10'sd0)) begin
      round_res_s = {sign_s, 31'h0};
    end else begin
      round_res_s = {sign_s, exp_fin_s[7:0], frac_s};
    end
  end

  // Next-state decode for the sequencing FSM
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (special_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = MUL;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (step_r == 5'd23) begin
          state_nxt_s = NORM;
        end else begin
          state_nxt_s = MUL;
        end
      end
      NORM:    state_nxt_s = ROUND;
      ROUND:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered done/busy, which follow the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done    <= (state_nxt_s == DONE);
      busy    <= (state_nxt_s != IDLE);
    end
  end

  // Datapath: latch operands, run the multiply steps, normalise, write the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r        <= 32'h0;
      b_r        <= 32'h0;
      step_r     <= 5'd0;
      prod_r     <= 48'h0;
      sticky_r   <= 1'b0;
      norm_r     <= 1'b0;
      result_out <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= A_in;
            b_r      <= B_in;
            step_r   <= 5'd0;
            prod_r   <= 48'h0;
            sticky_r <= 1'b0;
            norm_r   <= 1'b0;
            if (special_s) begin
              result_out <= special_res_s;
            end
          end
        end
        MUL: begin
          prod_r <= {sum_s, prod_r[23:1]};
          step_r <= step_r + 5'd1;
        end
        NORM: begin
          if (prod_r[47]) begin
            prod_r   <= {1'b0, prod_r[47:1]};
            sticky_r <= prod_r[0];
            norm_r   <= 1'b1;
          end else begin
            sticky_r <= 1'b0;
            norm_r   <= 1'b0;
          end
        end
        ROUND: begin
          result_out <= round_res_s;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq.
module tb_fp_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] result_out;
  logic        done;
  logic        busy;

  int total;
  int passed;

  fp_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A_in       (A_in),
    .B_in       (B_in),
    .result_out (result_out),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation at E0 and check latency, busy, result and the done strobe.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    int busy_bad;
    logic seen;
    @(negedge clk);
    A_in  = a;
    B_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    busy_bad = 0;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_bad++;
        @(posedge clk);
        #1;
        n++;
      end
    end
    check({tag, " done_seen"}, {31'h0, seen}, 32'd1);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, result_out, exp_res);
    check({tag, " busy_during"}, busy_bad, 32'd0);
    check({tag, " busy_in_done"}, {31'h0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({tag, " done_one_cycle"}, {31'h0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'h0, busy}, 32'd0);
    check({tag, " result_hold"}, result_out, exp_res);
  endtask

  initial begin
    int pulses;
    logic [31:0] round_exp;
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    start  = 1'b0;
    A_in   = 32'h0;
    B_in   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset done", {31'h0, done}, 32'd0);
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset result", result_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Normal-path products
    run_op("1x2", 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 26);
    run_op("3x-2", 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, 26);
    run_op("overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 26);
    run_op("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 26);

`ifdef FP_MUL_ROUND_EN
    round_exp = 32'h4010_0002;
`else
    round_exp = 32'h4010_0001;
`endif
    run_op("rounding", 32'h3FC0_0001, 32'h3FC0_0001, round_exp, 26);

    // Special-case path
    run_op("infx0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
    run_op("subnormal", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 0);
    run_op("nan", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
    run_op("neginf", 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 0);
    run_op("negzero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 0);

    // start held high with new operands during MUL must be ignored
    @(negedge clk);
    A_in  = 32'h3F80_0000;
    B_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    A_in  = 32'h4040_0000;
    B_in  = 32'hC000_0000;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        check("held_start result", result_out, 32'h4000_0000);
      end
      @(posedge clk);
      #1;
    end
    check("held_start pulses", pulses, 32'd1);

    // Reset in the middle of MUL aborts the operation
    @(negedge clk);
    A_in  = 32'h4040_0000;
    B_in  = 32'hC000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort done", {31'h0, done}, 32'd0);
    check("abort busy", {31'h0, busy}, 32'd0);
    check("abort result", result_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort no_done", pulses, 32'd0);
    run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 26);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-004 SHALL have port A_in, input, 32 bits: IEEE-754 binary32 multiplicand, sampled with start.
REQ-005 SHALL have port B_in, input, 32 bits: IEEE-754 binary32 multiplier, sampled with start.
REQ-006 SHALL have port result_out, output, 32 bits: binary32 product, registered.
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion strobe, registered.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, MUL, NORM, ROUND, DONE.
REQ-010 IDLE with start=1 at edge E0 SHALL latch A_in/B_in, then go to MUL (normal operands) or DONE (special case).
REQ-011 MUL SHALL run a 24-step shift-add multiply of the 24-bit significands (hidden bit included) into a 48-bit product, one step per cycle, via a 5-bit step counter.
REQ-012 After the 24th MUL step (edge E24), SHALL go to NORM (E25), then ROUND (E26), then DONE; done=1 for exactly the cycle after E26, and IDLE follows at E27.
REQ-013 Special-case path: done SHALL be high in the cycle after E0, then IDLE.
REQ-014 start asserted outside IDLE SHALL be ignored, and operand registers SHALL stay unchanged.
REQ-015 result_out SHALL update only on entry to DONE and hold until the next completion.
REQ-016 sign = A[31] XOR B[31]; exponent = EA + EB - 127, computed at least 10 bits signed.
REQ-017 NORM: if product bit 47 is set, SHALL shift right by 1 and increment the exponent.
REQ-018 ROUND SHALL apply round-to-nearest-even using guard/round/sticky bits; a mantissa carry-out SHALL increment the exponent.
REQ-019 Final exponent >= 255 SHALL give signed infinity (exp 8'hFF, mantissa 0).
REQ-020 Final exponent <= 0 SHALL give signed zero (flush to zero).
REQ-021 Subnormal inputs (exp 0) SHALL be treated as signed zero.
REQ-022 Any NaN input, or Inf x 0, SHALL give canonical NaN 32'h7FC00000.
REQ-023 Inf x finite-nonzero SHALL give signed Inf; zero x finite SHALL give signed zero.

Reset
REQ-024 rst=0 SHALL immediately force: state IDLE, done=0, busy=0, result_out=32'h0, step counter=0, operand registers 0.
REQ-025 Reset during any non-IDLE state SHALL abort the operation with no done pulse; after rst deasserts, the next start SHALL complete normally.

Configuration
REQ-026 SHALL honour macro FP_MUL_ROUND_EN.
REQ-027 With FP_MUL_ROUND_EN defined: ROUND performs round-to-nearest-even per REQ-018.
REQ-028 Without FP_MUL_ROUND_EN: ROUND truncates (round toward zero), still occupies one cycle, and latency is unchanged.

Verification
REQ-029 A=3F800000, B=40000000, start at E0 -> result_out=40000000, done high only in the cycle after E26, busy high E0..E26.
REQ-030 A=40400000, B=C0000000 -> C0C00000; A=7F000000, B=7F000000 -> 7F800000.
REQ-031 A=7F800000, B=00000000 -> 7FC00000, done in the cycle after E0; A=00000001, B=3F800000 -> 00000000.
REQ-032 A=B=3FC00001 -> 40100002 with FP_MUL_ROUND_EN defined, 40100001 without it.
REQ-033 start held high during MUL with new operands -> first result unaffected and only one done pulse.
REQ-034 rst pulsed low at E10 -> done=0, busy=0, result_out=0; then 3F800000 x 3F800000 -> 3F800000 with full latency.
